// File: rtl/ff_force_pkg.sv
// Shared types for the flip-flop override scheduler: FSM state encoding and op codes.
package ff_force_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORCE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/ff_force_sched_arb.sv
// Round-robin picker: first asserted req at or above ptr, wrapping; purely combinational.
// Zero latency; no backpressure, vld simply reports that some req was high.
module rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic             vld
);

  int j;

  always_comb begin
    win = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!vld && req[j]) begin
        win[j] = 1'b1;
        vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ff_force_sched.sv
// Shares one set/clear override slot of a flip-flop bank among NREQ requesters, round-robin.
// Grant and override appear 1 cycle after req is seen in IDLE; req must stay high until gnt.
module ff_force_sched
  import ff_force_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int WIDTH  = 8,
  parameter  int HOLD_W = 4,
  localparam int IDX_W  = $clog2(WIDTH),
  localparam int PTR_W  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_op,
  input  logic [NREQ*IDX_W-1:0]    req_idx,
  input  logic [NREQ*HOLD_W-1:0]   req_hold,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [WIDTH-1:0]         s_out,
  output logic [WIDTH-1:0]         r_out,
  output logic                     busy
);

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]   own_q, own_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [NREQ-1:0]   win;
  logic              win_vld;
  logic              op_w;
  logic [IDX_W-1:0]  idx_w;
  int                widx;

  // Out-of-range indices decode to an all-zero mask, so the slot is sequenced but drives nothing.
  function automatic logic [WIDTH-1:0] bit_mask(input logic [IDX_W-1:0] i);
    bit_mask = '0;
    for (int b = 0; b < WIDTH; b++)
      if (int'(i) == b) bit_mask[b] = 1'b1;
  endfunction

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .vld (win_vld)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    gnt_d   = '0;
    done_d  = '0;
    s_d     = s_q;
    r_d     = r_q;
    op_w    = OP_CLR;
    idx_w   = '0;
    widx    = 0;
    case (state_q)
      IDLE: begin
        s_d = '0;
        r_d = '0;
        if (win_vld) begin
          for (int i = 0; i < NREQ; i++)
            if (win[i]) widx = i;
          op_w    = req_op[widx];
          idx_w   = req_idx[widx*IDX_W +: IDX_W];
          cnt_d   = req_hold[widx*HOLD_W +: HOLD_W];
          own_d   = win;
          gnt_d   = win;
          ptr_d   = PTR_W'((widx + 1) % NREQ);
          state_d = FORCE;
          if (op_w == OP_SET) s_d = bit_mask(idx_w);
          else                r_d = bit_mask(idx_w);
        end
      end
      FORCE: begin
        if (cnt_q == '0) begin
          state_d = RELEASE;
          s_d     = '0;
          r_d     = '0;
          done_d  = own_q;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
        s_d     = '0;
        r_d     = '0;
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
        r_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      own_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      s_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign s_out = s_q;
  assign r_out = r_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ff_force_sched.sv
// Directed bench for ff_force_sched: vector table plus hand sequences for round-robin, reset and range cases.
module tb_ff_force_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_op;
  logic [11:0] req_idx;
  logic [15:0] req_hold;
  logic [3:0]  gnt, done;
  logic [7:0]  s_out, r_out;
  logic        busy;

  logic        rst6;
  logic [3:0]  req6, op6;
  logic [11:0] idx6;
  logic [15:0] hold6;
  logic [3:0]  gnt6, done6;
  logic [5:0]  s6, r6;
  logic        busy6;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ff_force_sched #(.NREQ(4), .WIDTH(8), .HOLD_W(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_idx(req_idx),
    .req_hold(req_hold), .gnt(gnt), .done(done), .s_out(s_out), .r_out(r_out), .busy(busy)
  );

  ff_force_sched #(.NREQ(4), .WIDTH(6), .HOLD_W(4)) u_dut6 (
    .clk(clk), .rst(rst6), .req(req6), .req_op(op6), .req_idx(idx6),
    .req_hold(hold6), .gnt(gnt6), .done(done6), .s_out(s6), .r_out(r6), .busy(busy6)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       op;
    logic [2:0] idx;
    logic [3:0] hold;
    logic [3:0] gnt;
    logic [3:0] done;
    logic [7:0] s;
    logic [7:0] r;
    logic       busy;
  } vec_t;

  function automatic vec_t mk(logic rs, logic [3:0] rq, logic op, logic [2:0] idx, logic [3:0] hold,
                              logic [3:0] g, logic [3:0] d, logic [7:0] s, logic [7:0] r, logic b);
    vec_t v;
    v.rst = rs; v.req = rq; v.op = op; v.idx = idx; v.hold = hold;
    v.gnt = g; v.done = d; v.s = s; v.r = r; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic op, input logic [2:0] idx, input logic [3:0] hold);
    for (int i = 0; i < 4; i++) begin
      req_op[i]          = op;
      req_idx[i*3 +: 3]  = idx;
      req_hold[i*4 +: 4] = hold;
    end
  endtask

  function automatic int oh2idx(logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Invariants on both instances, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv_sr_excl", {24'b0, s_out & r_out}, 32'h0);
      chk("inv_sr_onehot", 32'($countones(s_out | r_out) <= 1), 32'h1);
      chk("inv_gnt_onehot", 32'($countones(gnt) <= 1), 32'h1);
      chk("inv_done_onehot", 32'($countones(done) <= 1), 32'h1);
    end
    if (!rst6) begin
      chk("inv6_sr_excl", {26'b0, s6 & r6}, 32'h0);
      chk("inv6_sr_onehot", 32'($countones(s6 | r6) <= 1), 32'h1);
    end
  end

  vec_t tbl[14];
  int   gw[4];
  int   gt[4];
  int   exp_rr[4];
  int   gcnt;

  initial begin
    rst = 1'b1; req = '0; req_op = '0; req_idx = '0; req_hold = '0;
    rst6 = 1'b1; req6 = '0; op6 = '0; idx6 = '0; hold6 = '0;

    //            rst req     op idx hold  gnt     done    s      r      busy
    tbl[0]  = mk(1, 4'b1111, 1, 0, 0, 4'b0000, 4'b0000, 8'h00, 8'h00, 0);
    tbl[1]  = mk(1, 4'b1111, 1, 0, 0, 4'b0000, 4'b0000, 8'h00, 8'h00, 0);
    tbl[2]  = mk(0, 4'b1111, 1, 0, 0, 4'b0001, 4'b0000, 8'h01, 8'h00, 1);
    tbl[3]  = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0001, 8'h00, 8'h00, 1);
    tbl[4]  = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 8'h00, 8'h00, 0);
    tbl[5]  = mk(0, 4'b0100, 1, 5, 3, 4'b0100, 4'b0000, 8'h20, 8'h00, 1);
    tbl[6]  = mk(0, 4'b0000, 1, 5, 3, 4'b0000, 4'b0000, 8'h20, 8'h00, 1);
    tbl[7]  = mk(0, 4'b0000, 1, 5, 3, 4'b0000, 4'b0000, 8'h20, 8'h00, 1);
    tbl[8]  = mk(0, 4'b0000, 1, 5, 3, 4'b0000, 4'b0000, 8'h20, 8'h00, 1);
    tbl[9]  = mk(0, 4'b0000, 1, 5, 3, 4'b0000, 4'b0100, 8'h00, 8'h00, 1);
    tbl[10] = mk(0, 4'b0000, 1, 5, 3, 4'b0000, 4'b0000, 8'h00, 8'h00, 0);
    tbl[11] = mk(0, 4'b0010, 0, 7, 0, 4'b0010, 4'b0000, 8'h00, 8'h80, 1);
    tbl[12] = mk(0, 4'b0000, 0, 7, 0, 4'b0000, 4'b0010, 8'h00, 8'h00, 1);
    tbl[13] = mk(0, 4'b0000, 0, 7, 0, 4'b0000, 4'b0000, 8'h00, 8'h00, 0);

    for (int v = 0; v < 14; v++) begin
      rst = tbl[v].rst;
      req = tbl[v].req;
      drive_all(tbl[v].op, tbl[v].idx, tbl[v].hold);
      tick();
      chk($sformatf("v%0d_gnt", v),  {28'b0, gnt},  {28'b0, tbl[v].gnt});
      chk($sformatf("v%0d_done", v), {28'b0, done}, {28'b0, tbl[v].done});
      chk($sformatf("v%0d_s", v),    {24'b0, s_out}, {24'b0, tbl[v].s});
      chk($sformatf("v%0d_r", v),    {24'b0, r_out}, {24'b0, tbl[v].r});
      chk($sformatf("v%0d_busy", v), {31'b0, busy}, {31'b0, tbl[v].busy});
    end

    // Round-robin with req=1011 held, hold=0: order 0,1,3,0, three cycles apart.
    exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 3; exp_rr[3] = 0;
    rst = 1'b1; req = '0; tick(); tick();
    rst = 1'b0; req = 4'b1011; drive_all(1'b1, 3'd2, 4'd0);
    gcnt = 0;
    for (int c = 0; c < 40 && gcnt < 4; c++) begin
      tick();
      if (gnt != 4'b0000) begin
        gw[gcnt] = oh2idx(gnt);
        gt[gcnt] = c;
        gcnt++;
      end
    end
    chk("rr_grant_count", 32'(gcnt), 32'd4);
    for (int k = 0; k < gcnt; k++) begin
      chk($sformatf("rr_order%0d", k), 32'(gw[k]), 32'(exp_rr[k]));
      if (k > 0) chk($sformatf("rr_spacing%0d", k), 32'(gt[k] - gt[k-1]), 32'd3);
    end
    req = '0;
    tick(); tick();
    chk("rr_idle_busy", {31'b0, busy}, 32'd0);

    // Reset on the 2nd FORCE cycle of a hold=5 grant to requester 1.
    req = 4'b0010; drive_all(1'b1, 3'd3, 4'd5);
    tick();
    chk("mid_gnt", {28'b0, gnt}, 32'h2);
    chk("mid_s1", {24'b0, s_out}, 32'h08);
    req = '0;
    tick();
    chk("mid_s2", {24'b0, s_out}, 32'h08);
    rst = 1'b1;
    tick();
    chk("mid_rst_s", {24'b0, s_out}, 32'h0);
    chk("mid_rst_r", {24'b0, r_out}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_done", {28'b0, done}, 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("mid_nodone%0d", c), {28'b0, done}, 32'h0);
      chk($sformatf("mid_idle%0d", c), {31'b0, busy}, 32'h0);
    end
    req = 4'b1111;
    tick();
    chk("mid_ptr_reset_gnt", {28'b0, gnt}, 32'h1);
    req = '0;
    tick(); tick();

    // Out-of-range index on the WIDTH=6 instance.
    rst6 = 1'b0; req6 = 4'b0001; op6 = 4'b1111; idx6 = {4{3'd7}}; hold6 = {4{4'd2}};
    tick();
    chk("oor_gnt", {28'b0, gnt6}, 32'h1);
    chk("oor_s_first", {26'b0, s6}, 32'h0);
    chk("oor_r_first", {26'b0, r6}, 32'h0);
    chk("oor_busy", {31'b0, busy6}, 32'h1);
    req6 = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("oor_s%0d", c), {26'b0, s6 | r6}, 32'h0);
      chk($sformatf("oor_nodone%0d", c), {28'b0, done6}, 32'h0);
    end
    tick();
    chk("oor_done", {28'b0, done6}, 32'h1);
    chk("oor_release_busy", {31'b0, busy6}, 32'h1);
    tick();
    chk("oor_idle_busy", {31'b0, busy6}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ff_force_sched.md
Name: ff_force_sched

Overview:
- Scheduler that shares the set/clear override inputs of a WIDTH-bit flip-flop bank among NREQ requesters.
- Each request names one bit, an operation (set or clear) and a hold length.
- The block grants requests round-robin, drives the chosen bit's s or r line for the hold length, then drops it for one cycle.
- It sits between control agents and the d_ff bank's s/r pins, so s and r are never asserted together and only one bit is overridden at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of flip-flops in the bank.
- HOLD_W, 4, width of the per-request hold count.
- IDX_W, $clog2(WIDTH), bit-index width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  request valid, one bit per requester; level, held until gnt.
- req_op  in  NREQ  per requester: 1 = set (drive s), 0 = clear (drive r).
- req_idx  in  NREQ*IDX_W  per requester target bit index, requester i at [i*IDX_W +: IDX_W].
- req_hold  in  NREQ*HOLD_W  per requester hold count, requester i at [i*HOLD_W +: HOLD_W].
- gnt  out  NREQ  one-hot, one-cycle grant pulse.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- s_out  out  WIDTH  set override to the bank, at most one bit high.
- r_out  out  WIDTH  clear override to the bank, at most one bit high.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state IDLE; gnt, done, s_out, r_out = 0; busy = 0; rr pointer = 0; counter = 0. Reset wins over all other events, including mid-FORCE. s_out/r_out are 0 from the first edge with rst=1, with no RELEASE cycle and no done.
- States: IDLE, FORCE, RELEASE. All outputs are registered.
- IDLE:
  - If any req bit is high at edge t, select winner w = first set bit searching from rr pointer upward, wrapping modulo NREQ.
  - Latch op, idx and hold of w; counter = hold.
  - Go to FORCE. At t+1: gnt[w]=1 for one cycle, and s_out[idx] (op=1) or r_out[idx] (op=0) = 1.
  - rr pointer = (w+1) mod NREQ.
  - With no req, stay in IDLE.
- FORCE:
  - Override stays asserted; counter decrements each cycle.
  - When counter==0, go to RELEASE. FORCE therefore lasts hold+1 cycles; hold=0 gives a one-cycle force.
  - req inputs are ignored while in FORCE.
- RELEASE (one cycle): s_out = r_out = 0; done[w] = 1; next state IDLE.
- Minimum spacing between consecutive grants is hold+3 cycles.
- A requester must keep req high until its gnt. If req drops before grant, no grant is issued and no error is raised.
- Requester w may hold req high through its own FORCE. It re-arbitrates in IDLE with pointer w+1, so it loses to any other pending requester.
- req_idx >= WIDTH: the request is granted and sequenced normally; s_out/r_out stay 0 throughout; done still pulses.
- Invariants: (s_out & r_out)==0; popcount(s_out|r_out) <= 1; popcount(gnt) <= 1; popcount(done) <= 1.

Decomposition:
- Package ff_force_pkg holds the state enum (IDLE, FORCE, RELEASE) and the OP_SET=1 / OP_CLR=0 constants.
- One sub-module, rr_arbiter (NREQ):
  - Inputs: req, pointer.
  - Outputs: one-hot winner plus a valid flag.
  - Purely combinational.
- FSM, counter and output drive live in ff_force_sched.

Test Plan:
- Reset: drive rst=1 for 2 cycles with req=4'b1111 -> all outputs 0, busy=0; the first grant after rst=0 goes to requester 0.
- Single set: req[2]=1, op=1, idx=5, hold=3 -> gnt=4'b0100 at t+1; s_out=8'h20 for 4 cycles; RELEASE with s_out=0 and done=4'b0100; busy falls 1 cycle later.
- Round-robin: req=4'b1011 held throughout, hold=0 -> grant order 0,1,3,0; consecutive grants exactly 3 cycles apart.
- Clear with hold=0: req[1]=1, op=0, idx=7 -> r_out=8'h80 for exactly 1 cycle; s_out stays 0.
- Reset mid-operation: rst=1 on the 2nd FORCE cycle of hold=5 -> s_out/r_out=0 the next cycle; no done pulse; pointer=0.
- Out-of-range index: WIDTH=6, idx=7 -> gnt and done pulse on schedule; s_out/r_out remain 0. Invariant assertions stay active in all tests.
